// File: rtl/clock_time_counter.sv
// Time-of-day core: TICK_DIV prescaler, BCD hh:mm:ss, mode/inc key setting FSM.
// Optional macro SET_BLINK_EN blanks the field being set for the first half of each second.
module clock_time_counter #(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [3:0] ch0,
    output logic [3:0] ch1,
    output logic [3:0] ch2,
    output logic [3:0] ch3,
    output logic [3:0] ch4,
    output logic [3:0] ch5,
    output logic [1:0] set_state,
    output logic       sec_tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] pre_cnt, pre_nxt;
    logic [7:0]    sec, minute, hour;
    logic [7:0]    sec_nxt, minute_nxt, hour_nxt;
    logic          tick_nxt;

    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9)
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_comb begin
        state_nxt  = state;
        pre_nxt    = (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PW'(1);
        sec_nxt    = sec;
        minute_nxt = minute;
        hour_nxt   = hour;
        tick_nxt   = 1'b0;
        case (state)
            RUN: begin
                // a mode press on the tick cycle swallows that tick
                if (mode_key) begin
                    state_nxt = SET_HOUR;
                end else if (pre_cnt == PRE_MAX) begin
                    tick_nxt = 1'b1;
                    sec_nxt  = inc_sixty(sec);
                    if (sec == 8'h59) begin
                        minute_nxt = inc_sixty(minute);
                        if (minute == 8'h59)
                            hour_nxt = inc_hour(hour);
                    end
                end
            end
            SET_HOUR: begin
                if (mode_key)
                    state_nxt = SET_MIN;
                else if (inc_key)
                    hour_nxt = inc_hour(hour);
            end
            SET_MIN: begin
                if (mode_key) begin
                    state_nxt = RUN;
                    sec_nxt   = 8'h00;
                    pre_nxt   = '0;
                end else if (inc_key) begin
                    minute_nxt = inc_sixty(minute);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pre_cnt  <= '0;
            sec      <= 8'h00;
            minute   <= 8'h00;
            hour     <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre_cnt  <= pre_nxt;
            sec      <= sec_nxt;
            minute   <= minute_nxt;
            hour     <= hour_nxt;
            sec_tick <= tick_nxt;
        end
    end

`ifdef SET_BLINK_EN
    logic [7:0] disp_minute, disp_hour;
    logic       blank;

    // blank decision uses next-cycle values so the display register lines up with pre_cnt
    assign blank = (pre_nxt < PW'(TICK_DIV / 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_hour   <= 8'h00;
            disp_minute <= 8'h00;
        end else begin
            disp_hour   <= (state_nxt == SET_HOUR && blank) ? 8'hFF : hour_nxt;
            disp_minute <= (state_nxt == SET_MIN && blank) ? 8'hFF : minute_nxt;
        end
    end

    assign {ch5, ch4} = disp_hour;
    assign {ch3, ch2} = disp_minute;
`else
    assign {ch5, ch4} = hour;
    assign {ch3, ch2} = minute;
`endif
    assign {ch1, ch0} = sec;
    assign set_state  = state;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter at TICK_DIV=4: constant vector table, corner sequences, random vs model.
module tb_clock_time_counter;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_key = 1'b0;
    logic       inc_key = 1'b0;
    logic [3:0] ch0, ch1, ch2, ch3, ch4, ch5;
    logic [1:0] set_state;
    logic       sec_tick;

    int total = 0;
    int bad   = 0;

    // reference model: plain integer time and prescaler
    int  m_h, m_m, m_s, m_pre, m_st;
    bit  m_tick;

    clock_time_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .mode_key(mode_key), .inc_key(inc_key),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4), .ch5(ch5),
        .set_state(set_state), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mk; bit ik; int h; int m; int s; int st; bit tick; int pre;
    } vec_t;

    function automatic logic [25:0] fmt(input int h, input int m, input int s,
                                        input int st, input bit tk, input int pre);
        logic [7:0] hh, mm, ss;
        hh = {4'(h / 10), 4'(h % 10)};
        mm = {4'(m / 10), 4'(m % 10)};
        ss = {4'(s / 10), 4'(s % 10)};
`ifdef SET_BLINK_EN
        if (st == 1 && pre < TD / 2) hh = 8'hFF;
        if (st == 2 && pre < TD / 2) mm = 8'hFF;
`endif
        return {hh, mm, ss, 2'(st), tk};
    endfunction

    function automatic logic [25:0] model_vec();
        return fmt(m_h, m_m, m_s, m_st, m_tick, m_pre);
    endfunction

    function automatic void model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_pre = 0; m_st = 0; m_tick = 1'b0;
    endfunction

    function automatic void model_edge(input bit mk, input bit ik);
        int nxt_pre;
        int t;
        m_tick  = 1'b0;
        nxt_pre = (m_pre + 1) % TD;
        if (m_st == 0) begin
            if (mk) m_st = 1;
            else if (m_pre == TD - 1) begin
                m_tick = 1'b1;
                t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600;
                m_m = (t / 60) % 60;
                m_s = t % 60;
            end
        end else if (m_st == 1) begin
            if (mk) m_st = 2;
            else if (ik) m_h = (m_h + 1) % 24;
        end else begin
            if (mk) begin
                m_st = 0; m_s = 0; nxt_pre = 0;
            end else if (ik) m_m = (m_m + 1) % 60;
        end
        m_pre = nxt_pre;
    endfunction

    task automatic check(input string name, input logic [25:0] exp);
        logic [25:0] act;
        act = {ch5, ch4, ch3, ch2, ch1, ch0, set_state, sec_tick};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // called at posedge+1: drive, take one edge, update model, return at posedge+1
    task automatic apply(input bit mk, input bit ik);
        mode_key = mk;
        inc_key  = ik;
        @(posedge clk);
        model_edge(mk, ik);
        #1;
        mode_key = 1'b0;
        inc_key  = 1'b0;
    endtask

    task automatic step(input bit mk, input bit ik, input string name);
        apply(mk, ik);
        check(name, model_vec());
    endtask

    task automatic goto_time(input int h, input int m);
        int n;
        step(1'b1, 1'b0, "enter_set_hour");
        n = (h - m_h + 24) % 24;
        repeat (n) step(1'b0, 1'b1, "set_hour_inc");
        step(1'b1, 1'b0, "enter_set_min");
        n = (m - m_m + 60) % 60;
        repeat (n) step(1'b0, 1'b1, "set_min_inc");
        step(1'b1, 1'b0, "exit_set");
    endtask

    task automatic run_ticks(input int n);
        repeat (n * TD) step(1'b0, 1'b0, "run");
    endtask

    vec_t tbl[17];
    int   sv_m, sv_s;

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 2};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 3};
        tbl[3]  = '{0, 0, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 1, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 0, 2};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 0, 3};
        tbl[7]  = '{1, 0, 0, 0, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 0, 1, 2, 0, 2};
        tbl[10] = '{0, 1, 1, 1, 1, 2, 0, 3};
        tbl[11] = '{0, 0, 1, 1, 1, 2, 0, 0};
        tbl[12] = '{1, 0, 1, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 1, 0, 0, 0, 1};
        tbl[14] = '{0, 0, 1, 1, 0, 0, 0, 2};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0, 3};
        tbl[16] = '{0, 0, 1, 1, 1, 0, 1, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 26'h0);
        rst_n = 1'b1;

        // first tick on 4th edge, inc ignored in RUN, mode on tick cycle, mode+inc, exit clears seconds
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].mk, tbl[i].ik);
            check($sformatf("table_%0d", i),
                  fmt(tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].st, tbl[i].tick, tbl[i].pre));
        end

        // hour wraps through 24 presses, minute through 60, nothing else moves
        sv_m = m_m;
        sv_s = m_s;
        step(1'b1, 1'b0, "enter_set_hour");
        repeat ((24 - m_h) % 24) step(1'b0, 1'b1, "hour_to_zero");
        repeat (25) begin
            step(1'b0, 1'b1, "hour_inc");
            step(1'b0, 1'b0, "hour_idle");
        end
        check("hour_25_presses", fmt(1, sv_m, sv_s, 1, 1'b0, m_pre));
        step(1'b1, 1'b0, "enter_set_min");
        repeat ((60 - m_m) % 60) step(1'b0, 1'b1, "min_to_zero");
        repeat (61) step(1'b0, 1'b1, "min_inc");
        check("min_61_presses", fmt(1, 1, sv_s, 2, 1'b0, m_pre));
        step(1'b1, 1'b0, "exit_set");

        // exit from set mode clears seconds and restarts the prescaler
        goto_time(12, 34);
        run_ticks(56);
        check("at_12_34_56", fmt(12, 34, 56, 0, 1'b1, 0));
        step(1'b1, 1'b0, "set_hour");
        step(1'b1, 1'b0, "set_min");
        step(1'b1, 1'b0, "exit");
        check("exit_clears_sec", fmt(12, 34, 0, 0, 1'b0, 0));
        repeat (TD - 1) begin
            apply(1'b0, 1'b0);
            check("no_early_tick", fmt(12, 34, 0, 0, 1'b0, 0));
        end
        apply(1'b0, 1'b0);
        check("tick_after_exit", fmt(12, 34, 1, 0, 1'b1, 0));

        // roll-overs
        goto_time(23, 59);
        run_ticks(59);
        check("at_23_59_59", fmt(23, 59, 59, 0, 1'b1, 0));
        run_ticks(1);
        check("roll_to_00", fmt(0, 0, 0, 0, 1'b1, 0));
        goto_time(9, 59);
        run_ticks(60);
        check("roll_to_10", fmt(10, 0, 0, 0, 1'b1, 0));
        goto_time(19, 59);
        run_ticks(60);
        check("roll_to_20", fmt(20, 0, 0, 0, 1'b1, 0));

        // asynchronous reset while in set mode
        step(1'b1, 1'b0, "pre_reset_set");
        step(1'b0, 1'b1, "pre_reset_inc");
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", 26'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (TD - 1) step(1'b0, 1'b0, "post_reset");
        apply(1'b0, 1'b0);
        check("post_reset_tick", fmt(0, 0, 1, 0, 1'b1, 0));

        // random keys against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

Time-of-day core of the digital clock. It divides the system clock down to a one-second tick and keeps hours, minutes and seconds as six BCD digits. Those digits feed the six-channel digit selector that drives the scanned display. Two single-cycle key pulses (mode, increment) let the user set hours and minutes.

## Interface

**Parameters**
- `TICK_DIV`, default 1000: number of `clk` cycles per second. Legal range is 4 to 2^20; an even value is required.

**Ports**
- `clk` input, 1 bit: system clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `mode_key` input, 1 bit: one-cycle pulse, already debounced and synchronised upstream. Advances the set-mode FSM.
- `inc_key` input, 1 bit: one-cycle pulse, already debounced and synchronised upstream. Increments the field being set.
- `ch0` output, 4 bits: seconds ones digit, BCD 0–9.
- `ch1` output, 4 bits: seconds tens digit, BCD 0–5.
- `ch2` output, 4 bits: minutes ones digit, BCD 0–9.
- `ch3` output, 4 bits: minutes tens digit, BCD 0–5.
- `ch4` output, 4 bits: hours ones digit, BCD 0–9 (0–3 when `ch5` = 2).
- `ch5` output, 4 bits: hours tens digit, BCD 0–2.
- `set_state` output, 2 bits: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN.
- `sec_tick` output, 1 bit: one-cycle pulse on each second advance in RUN.

## Operation

**Prescaler**
- `pre_cnt` counts 0 to `TICK_DIV`−1 and wraps. It runs in every state.

**FSM: RUN → SET_HOUR → SET_MIN → RUN**
- Each `mode_key` pulse moves one step along this sequence.
- `set_state` reflects the current state.

**RUN state**
- When `pre_cnt` = `TICK_DIV`−1 and `mode_key` = 0:
  - the seconds advance;
  - the carry ripples to minutes, then to hours;
  - `sec_tick` = 1 for that cycle.
- Roll-overs:
  - seconds 59 → 00 with carry to minutes;
  - minutes 59 → 00 with carry to hours;
  - hours 23 → 00.
- Digit carries:
  - a ones digit 9 → 0 increments its tens digit;
  - hours go 09 → 10 and 19 → 20.
- `inc_key` is ignored.

**SET_HOUR state**
- Time is frozen and `sec_tick` = 0.
- `inc_key` increments hours: 00 → … → 23 → 00.
- There is no carry into any other field. Minutes and seconds stay unchanged.

**SET_MIN state**
- Time is frozen and `sec_tick` = 0.
- `inc_key` increments minutes: 00 → … → 59 → 00.
- There is no carry into hours.

**Leaving SET_MIN**
- On the `mode_key` that leaves SET_MIN, seconds are cleared to 00 and `pre_cnt` is cleared to 0.
- The first tick after return therefore occurs `TICK_DIV` cycles after that edge.

**Priority and boundary rules**
- `mode_key` and `inc_key` in the same cycle: `mode_key` wins and `inc_key` is dropped.
- `mode_key` in the same cycle as a RUN tick: the state changes and that tick is discarded; time does not advance.
- Digit values outside their legal range cannot be reached. No input path loads an arbitrary value.

## Timing

**Reset**
- While `rst_n` = 0:
  - all six digits = 0;
  - `set_state` = 00;
  - `sec_tick` = 0;
  - `pre_cnt` = 0.
- Reset takes effect immediately, without waiting for a clock edge, including in the middle of set mode.
- After release, the first `sec_tick` comes on the `TICK_DIV`-th rising edge.

**Latency**
- All outputs are registered.
- A digit change, `set_state` change or `sec_tick` appears on the edge that samples the cause, so it is visible in the following cycle. The latency from a key pulse to the output is 1 cycle.
- `sec_tick` and the new time value become valid in the same cycle.
- The period between ticks in RUN is exactly `TICK_DIV` cycles.

## Configuration

- Macro: `SET_BLINK_EN`.
- **Defined:**
  - in SET_HOUR, `ch5`/`ch4` read 4'b1111 (the blank code understood downstream) while `pre_cnt` < `TICK_DIV`/2;
  - in SET_MIN, the same applies to `ch3`/`ch2`;
  - the other digits and the stored time are unaffected;
  - the outputs stay registered with 1-cycle latency.
- **Undefined:** digits always show the stored time; no blanking logic is built.

## Test plan

All scenarios use `TICK_DIV` = 4.

1. **Reset values:** assert `rst_n` = 0 mid-cycle → all `ch*` = 0, `set_state` = 00 and `sec_tick` = 0 immediately. Release → first `sec_tick` on the 4th edge, time 00:00:01.
2. **Full roll-over:** reach 23:59:59 via set mode plus ticks, then one more tick → 00:00:00 and `sec_tick` pulses once. Also from 09:59:59 → 10:00:00 and from 19:59:59 → 20:00:00.
3. **Set mode:** `mode_key` → `set_state` 01. Press `inc_key` 25 times from hour 00 → hours = 01, minutes and seconds unchanged, no `sec_tick` over 40 cycles. `mode_key` → 10. Press `inc_key` 61 times from minute 00 → minutes = 01, hours unchanged.
4. **Exit clears seconds:** from 12:34:56, go through SET_HOUR and SET_MIN and back to RUN → 12:34:00, next tick exactly 4 cycles after the exit edge.
5. **Simultaneous events:**
   - `mode_key` together with `inc_key` in SET_HOUR → `set_state` 10, hours unchanged;
   - `mode_key` in the tick cycle in RUN → `set_state` 01, seconds unchanged, no `sec_tick`.
6. **Blinking, with `SET_BLINK_EN` defined:** in SET_HOUR at 08:00:00, `ch5`/`ch4` = F/F for `pre_cnt` 0–1 and 0/8 for `pre_cnt` 2–3, while `ch3`–`ch0` stay 0. Without the macro, `ch5`/`ch4` hold 0/8 throughout.
